bytecode_sequencer: RTL and testbench
=====================================

# bytecode_sequencer

Multi-cycle fetch/decode/execute controller for the bytecode core. Fetches each opcode from program memory, presents it to the combinational `decoder`, then sequences the immediate-byte fetch, operand pops, execution-unit handshake, result push and PC update from the decoder's `argc`/`stackargs`/`stackwb`/`isgoto`/`iscmp` outputs. Sits between program ROM, `decoder`, operand stack and the ALU/comparator.

## Interface
- `PC_WIDTH`, 16, program counter / program address width

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `run`  in  1  level; start/continue execution
- `prog_rd`  out  1  program memory read strobe
- `prog_addr`  out  PC_WIDTH  program memory byte address
- `prog_data`  in  8  read data, valid the cycle after `prog_rd`
- `opcode`  out  8  instruction register, drives `decoder.opcode`
- `argc`  in  2  from decoder
- `stackargs`  in  2  from decoder
- `stackwb`  in  1  from decoder
- `isgoto`  in  1  from decoder
- `iscmp`  in  1  from decoder
- `arg`  out  16  collected immediate bytes, big-endian, zero-extended
- `stack_pop`  out  1  pop one stack entry this cycle
- `stack_push`  out  1  push execution result this cycle
- `exec_start`  out  1  one-cycle start pulse to ALU/comparator/LVA unit
- `exec_done`  in  1  execution complete; `cmp_taken` valid with it
- `cmp_taken`  in  1  branch condition true
- `busy`  out  1  state ≠ IDLE/HALT
- `halted`  out  1  state = HALT

## Operation
- States: IDLE, FETCH, DECODE, ARGREQ, ARGCAP, POP, EXEC, WB, NEXT, HALT.
- IDLE: `run`=1 → FETCH.
- FETCH: `prog_rd`=1, `prog_addr`=pc → DECODE.
- DECODE: `opcode`←`prog_data`; latch argc/stackargs/stackwb/isgoto/iscmp on the following cycle (decoder is combinational on `opcode`); clear `arg`; byte counter k←0. If opcode ∈ {0xAC IRETURN, 0xB0 ARETURN, 0xB1 RETURN} → HALT. Else argc>0 → ARGREQ, else stackargs>0 → POP, else EXEC.
- ARGREQ: `prog_rd`=1, `prog_addr`=pc+1+k → ARGCAP.
- ARGCAP: `arg`←{arg[7:0], prog_data}; k++. k<argc → ARGREQ; else POP (stackargs>0) or EXEC.
- POP: `stack_pop`=1 for exactly `stackargs` consecutive cycles → EXEC.
- EXEC: `exec_start`=1 on entry cycle only; wait for `exec_done` (sampled from the cycle after the start pulse). Latch taken = `iscmp` & `cmp_taken` at done. → WB.
- WB: `stack_push`=1 for one cycle iff `stackwb` → NEXT.
- NEXT: if `isgoto` or taken: pc ← pc + sign-extended arg[15:0] (offset relative to the opcode address); else pc ← pc + 1 + argc. Arithmetic modulo 2^PC_WIDTH. `run`=1 → FETCH, else IDLE.
- HALT: hold pc and `opcode`; `run`=0 → IDLE (pc retained; re-run restarts at halted pc).
- Undecoded opcodes behave as NOP (argc=stackargs=0, no push, no branch).

## Timing
- Reset (async assert, sync deassert): state IDLE, pc=0, `opcode`=0x00, `arg`=0; all strobes, `busy` and `halted` 0.
- Minimum instruction (NOP): FETCH, DECODE, EXEC, WB, NEXT = 5 cycles with zero-latency done; each arg byte +2, each pop +1, each exec wait cycle +1.
- `prog_rd` one cycle per byte; no read overlaps another.
- `stack_pop`/`stack_push` never asserted in the same cycle.
- `run` deasserted mid-instruction: instruction completes, returns to IDLE from NEXT.
- `exec_done` outside EXEC is ignored.
- Reset mid-instruction aborts immediately; no partial push/pop continues.
- pc wrap: 0xFFFF + 1 → 0x0000.

## Structure
- Shared package: state enum, return-opcode constants (alongside existing opcode header).
- Decoder instantiated by the parent, not inside this block. No sub-module; single FSM plus pc, k, arg, and latched decode-field registers.

## Test plan
- Program {0x10 BIPUSH, 0x2A, 0xB1}: `arg`=0x002A, one push, pc 0→2, HALT with `opcode`=0xB1, `halted`=1.
- {0x60 IADD} with `exec_done` delayed 3 cycles: exactly two `stack_pop` cycles, one `exec_start` pulse, one push, pc +1.
- GOTO at pc 0x0010, bytes 0xFF,0xFC: `arg`=0xFFFC, next fetch address 0x000C.
- IFEQ at 0x0020, offset 0x0008: `cmp_taken`=1 → pc 0x0028; `cmp_taken`=0 → pc 0x0023; one pop, no push.
- `rst_n` low during EXEC: all outputs to reset values same cycle, pc=0; restart fetches address 0.
- `run` dropped during POP of IMUL: instruction completes, state IDLE, `busy`=0, pc advanced by 1.

Source files
------------

// File: rtl/bytecode_sequencer_pkg.sv
// rtl/bytecode_sequencer_pkg.sv - shared state encoding and return-opcode constants
package bytecode_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ARGREQ = 4'd3,
        S_ARGCAP = 4'd4,
        S_POP    = 4'd5,
        S_EXEC   = 4'd6,
        S_WB     = 4'd7,
        S_NEXT   = 4'd8,
        S_HALT   = 4'd9
    } seq_state_t;

    localparam logic [7:0] OP_IRETURN = 8'hAC;
    localparam logic [7:0] OP_ARETURN = 8'hB0;
    localparam logic [7:0] OP_RETURN  = 8'hB1;

    // Any of the return family stops the sequencer.
    function automatic logic is_return(input logic [7:0] op);
        return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
    endfunction

endpackage

// File: rtl/bytecode_sequencer.sv
// rtl/bytecode_sequencer.sv - fetch/decode/execute sequencer for the bytecode core
module bytecode_sequencer
    import bytecode_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                prog_rd,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [7:0]          prog_data,
    output logic [7:0]          opcode,
    input  logic [1:0]          argc,
    input  logic [1:0]          stackargs,
    input  logic                stackwb,
    input  logic                isgoto,
    input  logic                iscmp,
    output logic [15:0]         arg,
    output logic                stack_pop,
    output logic                stack_push,
    output logic                exec_start,
    input  logic                exec_done,
    input  logic                cmp_taken,
    output logic                busy,
    output logic                halted
);

    seq_state_t          state, state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          opcode_q;
    logic [1:0]          k;
    logic [1:0]          pop_cnt;
    logic [1:0]          argc_q;
    logic [1:0]          sa_q;
    logic                wb_q, goto_q, cmp_q, taken_q;
    logic                exec_seen;
    logic [2:0]          k_inc;

    // While decoding, the fetched byte is forwarded so the external decoder
    // answers in the same cycle and the dispatch decision costs no extra state.
    assign opcode = (state == S_DECODE) ? prog_data : opcode_q;
    assign k_inc  = {1'b0, k} + 3'd1;
    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and per-state strobes.
    always_comb begin
        state_nxt  = state;
        prog_rd    = 1'b0;
        prog_addr  = pc;
        stack_pop  = 1'b0;
        stack_push = 1'b0;
        exec_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                prog_rd   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_return(prog_data)) state_nxt = S_HALT;
                else if (argc != 2'd0)    state_nxt = S_ARGREQ;
                else if (stackargs != 2'd0) state_nxt = S_POP;
                else                      state_nxt = S_EXEC;
            end
            S_ARGREQ: begin
                prog_rd   = 1'b1;
                prog_addr = pc + PC_WIDTH'(k) + PC_WIDTH'(1);
                state_nxt = S_ARGCAP;
            end
            S_ARGCAP: begin
                if (k_inc < {1'b0, argc_q}) state_nxt = S_ARGREQ;
                else if (sa_q != 2'd0)      state_nxt = S_POP;
                else                        state_nxt = S_EXEC;
            end
            S_POP: begin
                stack_pop = 1'b1;
                if (pop_cnt + 2'd1 == sa_q) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                exec_start = !exec_seen;
                if (exec_done) state_nxt = S_WB;
            end
            S_WB: begin
                stack_push = wb_q;
                state_nxt  = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (!run) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pc, instruction register, immediate collection, decode latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            opcode_q  <= 8'h00;
            arg       <= 16'h0000;
            k         <= 2'd0;
            pop_cnt   <= 2'd0;
            argc_q    <= 2'd0;
            sa_q      <= 2'd0;
            wb_q      <= 1'b0;
            goto_q    <= 1'b0;
            cmp_q     <= 1'b0;
            taken_q   <= 1'b0;
            exec_seen <= 1'b0;
        end else begin
            exec_seen <= (state == S_EXEC);
            case (state)
                S_DECODE: begin
                    opcode_q <= prog_data;
                    argc_q   <= argc;
                    sa_q     <= stackargs;
                    wb_q     <= stackwb;
                    goto_q   <= isgoto;
                    cmp_q    <= iscmp;
                    taken_q  <= 1'b0;
                    arg      <= 16'h0000;
                    k        <= 2'd0;
                    pop_cnt  <= 2'd0;
                end
                S_ARGCAP: begin
                    arg <= {arg[7:0], prog_data};
                    k   <= k + 2'd1;
                end
                S_POP: begin
                    pop_cnt <= pop_cnt + 2'd1;
                end
                S_EXEC: begin
                    if (exec_done) taken_q <= cmp_q & cmp_taken;
                end
                S_NEXT: begin
                    // Branch offsets are relative to the opcode address.
                    if (goto_q || taken_q) pc <= pc + PC_WIDTH'($signed(arg));
                    else                   pc <= pc + PC_WIDTH'(argc_q) + PC_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_sequencer.sv
// tb/tb_bytecode_sequencer.sv - scoreboard bench for bytecode_sequencer
module tb_bytecode_sequencer;

    localparam int K_RDOP = 0, K_RDARG = 1, K_POP = 2, K_START = 3, K_PUSH = 4, K_HALT = 5;

    typedef struct packed {
        logic [1:0] argc;
        logic [1:0] sa;
        logic       wb;
        logic       go;
        logic       cmp;
    } dec_t;

    typedef struct {
        int          kind;
        logic [23:0] val;
        int          gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic        prog_rd;
    logic [15:0] prog_addr;
    logic [7:0]  prog_data = 8'h00;
    logic [7:0]  opcode;
    logic [1:0]  argc, stackargs;
    logic        stackwb, isgoto, iscmp;
    logic [15:0] arg;
    logic        stack_pop, stack_push, exec_start;
    logic        exec_done, cmp_taken;
    logic        busy, halted;

    logic [7:0]  mem [0:65535];
    ev_t         exp_q[$];
    int          delay_q[$];
    bit          taken_q[$];
    int          force_delay[$];
    bit          force_taken[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_op = 0;
    int          resp_cnt = 0;
    bit          prev_halted = 1'b0;

    always #5 clk = ~clk;

    bytecode_sequencer #(.PC_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .argc(argc), .stackargs(stackargs), .stackwb(stackwb),
        .isgoto(isgoto), .iscmp(iscmp), .arg(arg),
        .stack_pop(stack_pop), .stack_push(stack_push), .exec_start(exec_start),
        .exec_done(exec_done), .cmp_taken(cmp_taken), .busy(busy), .halted(halted)
    );

    // Reference decoder table for the opcodes the bench exercises.
    function automatic dec_t dec(input logic [7:0] op);
        case (op)
            8'h10:   return '{2'd1, 2'd0, 1'b1, 1'b0, 1'b0}; // BIPUSH
            8'h11:   return '{2'd2, 2'd0, 1'b1, 1'b0, 1'b0}; // SIPUSH
            8'h15:   return '{2'd1, 2'd0, 1'b1, 1'b0, 1'b0}; // ILOAD
            8'h36:   return '{2'd1, 2'd1, 1'b0, 1'b0, 1'b0}; // ISTORE
            8'h57:   return '{2'd0, 2'd1, 1'b0, 1'b0, 1'b0}; // POP
            8'h60:   return '{2'd0, 2'd2, 1'b1, 1'b0, 1'b0}; // IADD
            8'h68:   return '{2'd0, 2'd2, 1'b1, 1'b0, 1'b0}; // IMUL
            8'h99:   return '{2'd2, 2'd1, 1'b0, 1'b0, 1'b1}; // IFEQ
            8'h9F:   return '{2'd2, 2'd2, 1'b0, 1'b0, 1'b1}; // IF_ICMPEQ
            8'hA7:   return '{2'd2, 2'd0, 1'b0, 1'b1, 1'b0}; // GOTO
            default: return '0;
        endcase
    endfunction

    always_comb {argc, stackargs, stackwb, isgoto, iscmp} = dec(opcode);

    // Program ROM: data valid the cycle after the read strobe.
    always @(posedge clk) if (prog_rd) prog_data <= mem[prog_addr];

    // Execution-unit responder: delay and branch outcome come from the model's queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_cnt  = 0;
            exec_done = 1'b0;
        end else begin
            exec_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) exec_done = 1'b1;
            end else if (exec_start) begin
                int dl;
                dl        = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                cmp_taken = (taken_q.size() > 0) ? taken_q.pop_front() : 1'b0;
                if (dl == 0) exec_done = 1'b1;
                else resp_cnt = dl;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic got(input bit is_rd, input int kind, input logic [23:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val 0x%06h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if ((is_rd ? !(e.kind == K_RDOP || e.kind == K_RDARG) : (e.kind != kind)) || e.val !== val) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d val 0x%06h, expected kind %0d val 0x%06h",
                         kind, val, e.kind, e.val);
            end else if (e.kind == K_RDOP) begin
                if (e.gap != 0) check("fetch_gap", cyc - last_op, e.gap);
                last_op = cyc;
            end
        end
    endtask

    // Monitor: every observable strobe is matched against the expected event stream.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stack_pop || stack_push) check("pop_push_exclusive", {stack_pop, stack_push} == 2'b11, 0);
            if (prog_rd)    got(1'b1, K_RDOP, {8'h00, prog_addr});
            if (stack_pop)  got(1'b0, K_POP, 24'h0);
            if (exec_start) got(1'b0, K_START, {opcode, arg});
            if (stack_push) got(1'b0, K_PUSH, 24'h0);
            if (halted && !prev_halted) got(1'b0, K_HALT, {16'h0, opcode});
        end
        prev_halted = halted;
    end

    // Instruction-level reference: walks the program and lists the strobes each instruction must produce.
    task automatic model(input logic [15:0] start, input int max_n, output logic [15:0] pc_out);
        logic [15:0] pc, a, addr;
        logic [7:0]  op;
        dec_t        d;
        int          gap, dl;
        bit          tk;
        pc  = start;
        gap = 0;
        for (int n = 0; n < max_n; n++) begin
            op = mem[pc];
            exp_q.push_back('{K_RDOP, {8'h00, pc}, gap});
            if (op == 8'hAC || op == 8'hB0 || op == 8'hB1) begin
                exp_q.push_back('{K_HALT, {16'h0, op}, 0});
                break;
            end
            d = dec(op);
            a = 16'h0;
            for (int k = 0; k < int'(d.argc); k++) begin
                addr = pc + 16'(1 + k);
                exp_q.push_back('{K_RDARG, {8'h00, addr}, 0});
                a = {a[7:0], mem[addr]};
            end
            for (int p = 0; p < int'(d.sa); p++) exp_q.push_back('{K_POP, 24'h0, 0});
            dl = (force_delay.size() > 0) ? force_delay.pop_front() : int'($urandom_range(0, 3));
            tk = (force_taken.size() > 0) ? force_taken.pop_front() : 1'($urandom_range(0, 1));
            delay_q.push_back(dl);
            taken_q.push_back(tk);
            exp_q.push_back('{K_START, {op, a}, 0});
            if (d.wb) exp_q.push_back('{K_PUSH, 24'h0, 0});
            gap = 5 + 2 * int'(d.argc) + int'(d.sa) + dl;
            if (d.go || (d.cmp && tk)) pc = pc + a;
            else pc = pc + 16'(1 + int'(d.argc));
        end
        pc_out = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        run   = 1'b0;
        rst_n = 1'b0;
        exp_q.delete(); delay_q.delete(); taken_q.delete();
        force_delay.delete(); force_taken.delete();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (halted && exp_q.size() == 0) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic build_random();
        logic [7:0]  tbl [13];
        logic [7:0]  ops [$];
        logic [15:0] adr [$];
        logic [15:0] a, off;
        dec_t        d;
        int          len, j;
        tbl = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h15, 8'h36, 8'h57, 8'h60, 8'h68, 8'h99, 8'h9F, 8'hA7, 8'hFE};
        len = $urandom_range(6, 14);
        a = 16'h0;
        for (int i = 0; i < len - 1; i++) begin
            ops.push_back(tbl[$urandom_range(0, 12)]);
            adr.push_back(a);
            a = a + 16'(1 + int'(dec(ops[i]).argc));
        end
        ops.push_back(8'hB1);
        adr.push_back(a);
        for (int i = 0; i < len; i++) begin
            d = dec(ops[i]);
            mem[adr[i]] = ops[i];
            if (d.go || d.cmp) begin
                j   = $urandom_range(i + 1, len - 1);
                off = adr[j] - adr[i];
                mem[adr[i] + 16'd1] = off[15:8];
                mem[adr[i] + 16'd2] = off[7:0];
            end else begin
                for (int k = 0; k < int'(d.argc); k++) mem[adr[i] + 16'(1 + k)] = 8'($urandom);
            end
        end
    endtask

    task automatic run_to_halt(input string name);
        logic [15:0] p;
        model(16'h0000, 64, p);
        run = 1'b1;
        wait_halt(name);
        run = 1'b0;
    endtask

    initial begin
        logic [15:0] p;
        bit          seen;
        rst_n = 1'b0; run = 1'b0; exec_done = 1'b0; cmp_taken = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_strobes", {prog_rd, stack_pop, stack_push, exec_start, busy, halted}, 0);
        check("reset_regs", {prog_addr, opcode, arg}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_busy", busy, 0);

        // BIPUSH 0x2A; RETURN, then re-run from the halted pc.
        do_reset();
        mem[0] = 8'h10; mem[1] = 8'h2A; mem[2] = 8'hB1;
        run_to_halt("bipush_halt");
        check("halt_opcode", opcode, 8'hB1);
        check("halted_flag", halted, 1);
        check("halted_not_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("halt_to_idle", halted, 0);
        model(16'h0002, 8, p);
        run = 1'b1;
        wait_halt("rerun_halted_pc");
        run = 1'b0;

        // IADD with a 3-cycle exec delay.
        do_reset();
        mem[0] = 8'h60; mem[1] = 8'hB1;
        force_delay.push_back(3);
        run_to_halt("iadd_delay3");

        // Backward GOTO at 0x0010.
        do_reset();
        mem[16'h00] = 8'hA7; mem[16'h01] = 8'h00; mem[16'h02] = 8'h10;
        mem[16'h0C] = 8'hB1;
        mem[16'h10] = 8'hA7; mem[16'h11] = 8'hFF; mem[16'h12] = 8'hFC;
        run_to_halt("goto_back");

        // IFEQ at 0x0020, taken then not taken.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            mem[16'h00] = 8'hA7; mem[16'h01] = 8'h00; mem[16'h02] = 8'h20;
            mem[16'h20] = 8'h99; mem[16'h21] = 8'h00; mem[16'h22] = 8'h08;
            mem[16'h23] = 8'hB1; mem[16'h28] = 8'hB1;
            force_taken.push_back(1'b0);
            force_taken.push_back(t == 0);
            run_to_halt(t == 0 ? "ifeq_taken" : "ifeq_not_taken");
        end

        // pc wrap: branch to 0xFFFF, NOP there wraps to 0x0000.
        do_reset();
        mem[16'h0000] = 8'h99; mem[16'h0001] = 8'hFF; mem[16'h0002] = 8'hFF;
        mem[16'h0003] = 8'hB1; mem[16'hFFFF] = 8'h00;
        force_taken.push_back(1'b1); force_taken.push_back(1'b0); force_taken.push_back(1'b0);
        run_to_halt("pc_wrap");

        // Reset asserted while waiting in EXEC.
        do_reset();
        mem[0] = 8'h60; mem[1] = 8'hB1;
        force_delay.push_back(6);
        model(16'h0000, 8, p);
        run  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (exec_start) seen = 1'b1;
        end
        check("exec_start_seen", seen, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("midexec_reset_strobes", {prog_rd, stack_pop, stack_push, exec_start, busy, halted}, 0);
        check("midexec_reset_regs", {prog_addr, opcode, arg}, 0);
        exp_q.delete(); delay_q.delete(); taken_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_to_halt("restart_after_reset");

        // run dropped during the POP phase of IMUL.
        do_reset();
        mem[0] = 8'h68; mem[1] = 8'hB1;
        model(16'h0000, 1, p);
        run  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (stack_pop) seen = 1'b1;
        end
        check("imul_pop_seen", seen, 1);
        run  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        check("run_drop_idle", seen, 1);
        check("run_drop_completed", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check("run_drop_not_halted", halted, 0);
        model(p, 8, p);
        run = 1'b1;
        wait_halt("run_drop_resume_pc1");
        run = 1'b0;

        // Randomised straight-line programs with forward branches.
        for (int r = 0; r < 20; r++) begin
            do_reset();
            build_random();
            run_to_halt("random_program");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
